// File: rtl/wb_commit.sv
// wb_commit: writeback value select, AES result FIFO merge, pending mask and retired-instruction counter
module wb_commit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        lui,
  input  logic        auipc,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] inst,
  input  logic [31:0] j_type,
  input  logic [31:0] u_type,
  input  logic [31:0] alu_result,
  input  logic [31:0] load_data,
  input  logic        aes_valid,
  input  logic [4:0]  aes_rd,
  input  logic [31:0] aes_data,
  output logic        aes_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] aes_pending,
  output logic [63:0] instret
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [4:0]    rd;
  logic [6:0]    opc;
  logic          pw, push, pop;
  logic [31:0]   wsel;
  always_comb begin
    rd = inst[11:7];
    opc = inst[6:0];
    pw = start & reg_write & (rd != 5'd0);
    aes_ready = (cnt != (AW+1)'(DEPTH)) & ~reset;
    push = aes_valid & aes_ready & (aes_rd != 5'd0);
    pop = ~pw & (cnt != '0);
    wsel = (lui | auipc) ? u_type :
           (opc == 7'b1101111 || opc == 7'b1100111) ? j_type :
           mem_to_reg ? load_data : alu_result;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp] <= aes_rd;
      q_data[wp] <= aes_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
      instret <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      rf_we <= pw | pop;
      if (pw) begin
        rf_rd <= rd;
        rf_wdata <= wsel;
      end else if (pop) begin
        rf_rd <= q_rd[rp];
        rf_wdata <= q_data[rp];
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (start && inst != '0) instret <= instret + 64'd1;
    end
  end
  for (genvar n = 0; n < 32; n++) begin : g_pend
    logic [AW:0] c;
    always_ff @(posedge clk) begin
      if (reset) c <= '0;
      else c <= c + (AW+1)'(push && aes_rd == 5'(n)) - (AW+1)'(pop && q_rd[rp] == 5'(n));
    end
    assign aes_pending[n] = c != '0;
  end
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: scoreboard bench for wb_commit with a behavioural FIFO model
module tb_wb_commit;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, lui = 1'b0, auipc = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0;
  logic [31:0] inst = '0, j_type = '0, u_type = '0, alu_result = '0, load_data = '0;
  logic        aes_valid = 1'b0;
  logic [4:0]  aes_rd = '0;
  logic [31:0] aes_data = '0;
  logic        aes_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata, aes_pending;
  logic [63:0] instret;

  typedef struct {logic we; logic [4:0] rd; logic [31:0] d;} exp_t;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  exp_t exp_q[$];
  ent_t mfifo[$];
  logic [4:0]  last_rd = '0;
  logic [31:0] last_d = '0;
  logic [63:0] mi = '0;
  int checks = 0, errors = 0;

  wb_commit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .lui(lui), .auipc(auipc),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .inst(inst), .j_type(j_type),
    .u_type(u_type), .alu_result(alu_result), .load_data(load_data),
    .aes_valid(aes_valid), .aes_rd(aes_rd), .aes_data(aes_data), .aes_ready(aes_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .aes_pending(aes_pending),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mpend();
    logic [31:0] p = '0;
    foreach (mfifo[i]) p[mfifo[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] sel();
    if (lui || auipc) return u_type;
    if (inst[6:0] == 7'b1101111 || inst[6:0] == 7'b1100111) return j_type;
    if (mem_to_reg) return load_data;
    return alu_result;
  endfunction

  task automatic step();
    exp_t e;
    ent_t f;
    logic pw, rdy, pop;
    if (reset) begin
      mfifo.delete();
      last_rd = '0;
      last_d = '0;
      mi = '0;
      e = '{1'b0, 5'd0, 32'd0};
    end else begin
      pw = start && reg_write && inst[11:7] != 5'd0;
      rdy = mfifo.size() < DEPTH;
      pop = !pw && mfifo.size() > 0;
      e.we = pw || pop;
      if (pw) begin
        last_rd = inst[11:7];
        last_d = sel();
      end else if (pop) begin
        f = mfifo.pop_front();
        last_rd = f.rd;
        last_d = f.d;
      end
      e.rd = last_rd;
      e.d = last_d;
      if (aes_valid && rdy && aes_rd != 5'd0) mfifo.push_back('{aes_rd, aes_data});
      if (start && inst != '0) mi++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rf_we", 64'(rf_we), 64'(e.we));
    chk("rf_rd", 64'(rf_rd), 64'(e.rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
    chk("aes_pending", 64'(aes_pending), 64'(mpend()));
    chk("instret", instret, mi);
    chk("aes_ready", 64'(aes_ready), 64'(!reset && mfifo.size() < DEPTH));
  endtask

  function automatic logic [31:0] mk(input logic [4:0] r, input logic [6:0] op);
    return {20'h00123, r, op};
  endfunction

  initial begin
    step();
    step();
    reset = 1'b0;
    #1 chk("ready_after_reset", 64'(aes_ready), 64'd1);
    start = 1'b1; reg_write = 1'b1; lui = 1'b1;
    inst = mk(5'd5, 7'b0110111); u_type = 32'h12345000; alu_result = 32'hDEAD;
    step();
    lui = 1'b0; inst = mk(5'd5, 7'b1101111); j_type = 32'h104;
    step();
    inst = mk(5'd5, 7'b1100111); j_type = 32'h208;
    step();
    inst = mk(5'd5, 7'b0000011); mem_to_reg = 1'b1; load_data = 32'hFF;
    step();
    mem_to_reg = 1'b0; inst = mk(5'd6, 7'b0110011); alu_result = 32'h55AA;
    step();
    inst = mk(5'd0, 7'b0110011);
    step();
    start = 1'b0; inst = mk(5'd5, 7'b0110011);
    step();
    reg_write = 1'b0; aes_valid = 1'b1; aes_rd = 5'd7; aes_data = 32'hA5A5A5A5;
    step();
    aes_valid = 1'b0;
    step();
    step();
    start = 1'b1; reg_write = 1'b1; inst = mk(5'd10, 7'b0110011); alu_result = 32'h1111;
    aes_valid = 1'b1; aes_rd = 5'd3; aes_data = 32'h1;
    step();
    aes_data = 32'h2; alu_result = 32'h2222;
    step();
    aes_rd = 5'd4; aes_data = 32'h3; alu_result = 32'h3333;
    step();
    aes_valid = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    aes_valid = 1'b1; aes_rd = 5'd11; aes_data = 32'hB0B0;
    step();
    aes_rd = 5'd9; aes_data = 32'h9999;
    step();
    aes_valid = 1'b0;
    step();
    aes_valid = 1'b1; aes_rd = 5'd0; aes_data = 32'hDEAD0;
    step();
    aes_valid = 1'b0;
    step();
    start = 1'b1; reg_write = 1'b1; inst = mk(5'd12, 7'b0110011);
    aes_valid = 1'b1; aes_rd = 5'd3; aes_data = 32'h33;
    step();
    aes_rd = 5'd6; aes_data = 32'h66;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("ready_after_mid_reset", 64'(aes_ready), 64'd1);
    start = 1'b0; reg_write = 1'b0; aes_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 300; i++) begin
      start = $urandom_range(0, 3) != 0;
      reg_write = $urandom_range(0, 1) == 1;
      lui = $urandom_range(0, 5) == 0;
      auipc = $urandom_range(0, 5) == 0;
      mem_to_reg = $urandom_range(0, 2) == 0;
      inst = $urandom_range(0, 9) == 0 ? 32'd0 : $urandom();
      if ($urandom_range(0, 2) == 0) inst[6:0] = $urandom_range(0, 1) ? 7'b1101111 : 7'b1100111;
      j_type = $urandom(); u_type = $urandom(); alu_result = $urandom(); load_data = $urandom();
      aes_valid = $urandom_range(0, 1) == 1;
      aes_rd = 5'($urandom_range(0, 7));
      aes_data = $urandom();
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
